xnor_match_pipe: RTL and testbench

//  Parametrised successor to the single-bit NOR-built XNOR cell: WIDTH-bit bitwise XNOR/XOR unit,
//  2-stage pipeline, valid/ready handshake. Emits match vector, popcount of ones, all-ones flag.

---
 rtl/xnor_match_pipe.sv | 119 +++++++++++
 tb/tb_xnor_match_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_match_pipe.sv
// rtl/xnor_match_pipe.sv - 2-stage NOR-built XNOR/XOR match unit with popcount and all-ones flag
// Optional running accumulator of accepted popcounts: define XNOR_MATCH_ACC_EN.
module xnor_match_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic                            mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_vec,
  output logic [$clog2(WIDTH+1)-1:0]      out_cnt,
  output logic                            out_all
`ifdef XNOR_MATCH_ACC_EN
  ,
  input  logic                            acc_clr,
  output logic [ACC_W-1:0]                acc
`endif
);

  localparam int CNT_W = $clog2(WIDTH+1);

  // An accumulator narrower than the popcount cannot hold a single beat.
  if (ACC_W < CNT_W) begin : g_acc_w_below_cnt_w
  end

  logic             s1_v;
  logic             s2_v;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] bit_res;
  logic [CNT_W-1:0] pop;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;

  // Per-bit XNOR/XOR from four/five NOR gates, same topology as the legacy cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic n1, n2, n3, xn, xo;
    assign n1 = ~(a[i] | b[i]);
    assign n2 = ~(a[i] | n1);
    assign n3 = ~(b[i] | n1);
    assign xn = ~(n2 | n3);
    assign xo = ~(xn | xn);
    assign bit_res[i] = mode ? xo : xn;
  end

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = !rst && s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_v;

  // Popcount of the stage-1 result, registered into stage 2.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(r[i]);
    end
  end

  // Stage 1: capture the bitwise result of an accepted beat; hold while blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      r    <= '0;
    end else if (s1_adv) begin
      s1_v <= in_fire;
      if (in_fire) begin
        r <= bit_res;
      end
    end
  end

  // Stage 2: output registers; held stable while out_valid and not out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      out_vec <= '0;
      out_cnt <= '0;
      out_all <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_vec <= r;
        out_cnt <= pop;
        out_all <= &r;
      end
    end
  end

`ifdef XNOR_MATCH_ACC_EN
  logic [ACC_W:0] acc_sum;

  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(out_cnt);

  // Saturating sum of popcounts on each output handshake; clear wins over the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      if (acc_clr) begin
        acc <= ACC_W'(out_cnt);
      end else if (acc_sum[ACC_W]) begin
        acc <= '1;
      end else begin
        acc <= acc_sum[ACC_W-1:0];
      end
    end else if (acc_clr) begin
      acc <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_xnor_match_pipe.sv
// tb/tb_xnor_match_pipe.sv - directed table-driven bench for xnor_match_pipe
module tb_xnor_match_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, mode, out_ready;
  logic [7:0] a, b;
  logic       in_ready, out_valid, out_all;
  logic [7:0] out_vec;
  logic [3:0] out_cnt;

  logic       in_valid1, mode1, out_ready1, a1, b1;
  logic       in_ready1, out_valid1, out_all1;
  logic       out_vec1;
  logic       out_cnt1;

`ifdef XNOR_MATCH_ACC_EN
  logic       acc_clr, acc_clr1;
  logic [3:0] acc;
  logic [15:0] acc1;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  xnor_match_pipe #(.WIDTH(8), .ACC_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_cnt(out_cnt), .out_all(out_all)
`ifdef XNOR_MATCH_ACC_EN
    , .acc_clr(acc_clr), .acc(acc)
`endif
  );

  xnor_match_pipe #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .mode(mode1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_vec(out_vec1), .out_cnt(out_cnt1), .out_all(out_all1)
`ifdef XNOR_MATCH_ACC_EN
    , .acc_clr(acc_clr1), .acc(acc1)
`endif
  );

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] vec;
    logic [3:0] cnt;
    logic       all;
  } tvec_t;

  tvec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [7:0] aa, input logic [7:0] bb);
    in_valid = v;
    mode = m;
    a = aa;
    b = bb;
  endtask

  initial begin
    logic [3:0] xnor_tt;
    logic       exp1[8];

    tv[0] = '{1'b0, 8'hA5, 8'hA5, 8'hFF, 4'd8, 1'b1};
    tv[1] = '{1'b1, 8'hA5, 8'h5A, 8'hFF, 4'd8, 1'b1};
    tv[2] = '{1'b0, 8'hF0, 8'h0F, 8'h00, 4'd0, 1'b0};
    tv[3] = '{1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
    tv[4] = '{1'b0, 8'h00, 8'h01, 8'hFE, 4'd7, 1'b0};
    tv[5] = '{1'b1, 8'h3C, 8'h0F, 8'h33, 4'd4, 1'b0};
    tv[6] = '{1'b0, 8'h12, 8'h34, 8'hD9, 4'd5, 1'b0};
    tv[7] = '{1'b1, 8'h80, 8'h00, 8'h80, 4'd1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    out_ready = 1'b1;
    in_valid1 = 1'b0; mode1 = 1'b0; a1 = 1'b0; b1 = 1'b0; out_ready1 = 1'b1;
`ifdef XNOR_MATCH_ACC_EN
    acc_clr = 1'b0; acc_clr1 = 1'b0;
`endif

    // Reset state.
    step();
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_all", out_all, 0);
`ifdef XNOR_MATCH_ACC_EN
    chk("rst_acc", acc, 0);
`endif
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Table: back-to-back stream, outputs two cycles after acceptance.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, tv[i].mode, tv[i].a, tv[i].b);
      else drive(1'b0, 1'b0, 8'h00, 8'h00);
      chk("tbl_in_ready", in_ready, 1);
      if (i >= 2) begin
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_out_vec", out_vec, tv[i-2].vec);
        chk("tbl_out_cnt", out_cnt, tv[i-2].cnt);
        chk("tbl_out_all", out_all, tv[i-2].all);
      end else begin
        chk("tbl_latency_valid", out_valid, 0);
      end
      step();
    end
    chk("tbl_drain_valid", out_valid, 0);

    // Stall: out_ready low, beats 01/03/07 as XOR with b=0.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h01, 8'h00);
    chk("stall_rdy0", in_ready, 1);
    step();
    drive(1'b1, 1'b1, 8'h03, 8'h00);
    chk("stall_rdy1", in_ready, 1);
    step();
    drive(1'b1, 1'b1, 8'h07, 8'h00);
    chk("stall_rdy2", in_ready, 0);
    chk("stall_valid2", out_valid, 1);
    chk("stall_vec2", out_vec, 8'h01);
    chk("stall_cnt2", out_cnt, 1);
    step();
    chk("stall_rdy3", in_ready, 0);
    chk("stall_hold_vec", out_vec, 8'h01);
    chk("stall_hold_cnt", out_cnt, 1);
    out_ready = 1'b1;
    #1;
    chk("stall_rdy_release", in_ready, 1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("stall_valid4", out_valid, 1);
    chk("stall_vec4", out_vec, 8'h03);
    chk("stall_cnt4", out_cnt, 2);
    step();
    chk("stall_valid5", out_valid, 1);
    chk("stall_vec5", out_vec, 8'h07);
    chk("stall_cnt5", out_cnt, 3);
    step();
    chk("stall_drain", out_valid, 0);

    // Reset with two beats in flight: nothing stale may surface.
    drive(1'b1, 1'b0, 8'hAA, 8'hAA);
    step();
    drive(1'b1, 1'b0, 8'h55, 8'h55);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
`ifdef XNOR_MATCH_ACC_EN
    chk("midrst_acc", acc, 0);
`endif
    step();
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_stale", out_valid, 0);
    end

    // WIDTH=1 sweep: {mode,a,b} = 0..7 streamed.
    xnor_tt = 4'b1001;
    for (int k = 0; k < 8; k++) exp1[k] = k[2] ? ~xnor_tt[k[1:0]] : xnor_tt[k[1:0]];
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        in_valid1 = 1'b1; mode1 = k[2]; a1 = k[1]; b1 = k[0];
      end else begin
        in_valid1 = 1'b0;
      end
      if (k >= 2) begin
        chk("w1_valid", out_valid1, 1);
        chk("w1_vec", out_vec1, exp1[k-2]);
        chk("w1_cnt", out_cnt1, exp1[k-2]);
        chk("w1_all", out_all1, exp1[k-2]);
      end
      step();
    end

`ifdef XNOR_MATCH_ACC_EN
    // Accumulator: saturation at 15, clear combined with a handshake, plain clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'hA5, 8'hA5);
    step();
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("acc_before", acc, 0);
    step();
    chk("acc_first", acc, 8);
    step();
    chk("acc_sat", acc, 15);
    drive(1'b1, 1'b1, 8'h07, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("acc_clr_beat_cnt", out_cnt, 3);
    acc_clr = 1'b1;
    step();
    chk("acc_clr_hs", acc, 3);
    step();
    acc_clr = 1'b0;
    chk("acc_clr_only", acc, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
